// File: rtl/vga_chk_pkg.sv
// Shared constants, FSM state type and the CRC-16-CCITT step function
// used by the VGA frame checker.
package vga_chk_pkg;

  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam int          CRC_MAX_W = 48;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    FRAME     = 1'b1
  } chk_state_t;

  // Feeds the low 'width' bits of data into the CRC, most significant bit first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                             input logic [CRC_MAX_W-1:0] data,
                                             input int width);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
      if (i < width) begin
        fb = c[15] ^ data[i];
        c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_crc16_acc.sv
// Registered CRC-16 accumulator; 'init' restarts from CRC_INIT and, when 'en'
// is also set, the same cycle's data word is folded into the fresh value.
module vga_crc16_acc
  import vga_chk_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       crc
);

  logic [15:0]          base;
  logic [CRC_MAX_W-1:0] data_ext;

  assign base     = init ? CRC_INIT : crc;
  assign data_ext = CRC_MAX_W'(data);

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc16_step(base, data_ext, DATA_W);
    end else if (init) begin
      crc <= CRC_INIT;
    end
  end

endmodule

// File: rtl/vga_frame_checker.sv
// Per-frame VGA stream checker: pixels per line, lines per frame, line period
// and a CRC of the pixel stream, latched and flagged once per closed frame.
module vga_frame_checker
  import vga_chk_pkg::*;
#(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int COLOR_W   = 4,
  parameter int HS_POL    = 1,
  parameter int VS_POL    = 1,
  parameter int CNT_W     = 12
) (
  input  logic               vga_clk,
  input  logic               vga_rst,
  input  logic               vga_hSync,
  input  logic               vga_vSync,
  input  logic               vga_colorEn,
  input  logic [COLOR_W-1:0] vga_color_r,
  input  logic [COLOR_W-1:0] vga_color_g,
  input  logic [COLOR_W-1:0] vga_color_b,
  input  logic [15:0]        exp_crc,
  output logic               frame_done,
  output logic [15:0]        frame_crc,
  output logic [CNT_W-1:0]   frame_lines,
  output logic [CNT_W-1:0]   h_period,
  output logic               pix_err,
  output logic               line_err,
  output logic               crc_ok,
  output logic [15:0]        frame_count
);

  localparam int               PIX_W   = 3 * COLOR_W;
  localparam logic             HS_ACT  = (HS_POL != 0);
  localparam logic             VS_ACT  = (VS_POL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_REQ   = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_REQ   = CNT_W'(V_DISPLAY);

  chk_state_t        state;
  logic              hs, vs, hs_d, vs_d, ce_d;
  logic              frame_start, hs_edge, line_close, in_frame;
  logic [CNT_W-1:0]  pcnt, lcnt, hcnt;
  logic              pix_acc, hs_seen;
  logic [CNT_W-1:0]  lines_close;
  logic              pix_close;
  logic [PIX_W-1:0]  pixel;
  logic [15:0]       crc;
  logic              crc_en;

  assign hs          = vga_hSync ~^ HS_ACT;
  assign vs          = vga_vSync ~^ VS_ACT;
  assign frame_start = vs & ~vs_d;
  assign hs_edge     = hs & ~hs_d;
  assign in_frame    = (state == FRAME);
  assign line_close  = in_frame & ce_d & ~vga_colorEn;
  assign pixel       = {vga_color_r, vga_color_g, vga_color_b};

  // Line/error totals including a line that closes in this very cycle, so a
  // close coinciding with frame_start is credited to the frame being closed.
  assign pix_close   = pix_acc | (line_close && (pcnt != H_REQ));
  assign lines_close = (line_close && (lcnt != CNT_MAX)) ? lcnt + 1'b1 : lcnt;

  // Pixels are ignored until armed; a pixel on frame_start opens the new frame.
  assign crc_en = vga_colorEn & (in_frame | frame_start);

  vga_crc16_acc #(
    .DATA_W(PIX_W)
  ) u_crc (
    .clk (vga_clk),
    .rst (vga_rst),
    .init(frame_start),
    .en  (crc_en),
    .data(pixel),
    .crc (crc)
  );

  always_ff @(posedge vga_clk) begin
    if (vga_rst) begin
      state       <= WAIT_SYNC;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      ce_d        <= 1'b0;
      pcnt        <= '0;
      lcnt        <= '0;
      hcnt        <= '0;
      pix_acc     <= 1'b0;
      hs_seen     <= 1'b0;
      frame_done  <= 1'b0;
      frame_crc   <= '0;
      frame_lines <= '0;
      h_period    <= '0;
      pix_err     <= 1'b0;
      line_err    <= 1'b0;
      crc_ok      <= 1'b0;
      frame_count <= '0;
    end else begin
      hs_d       <= hs;
      vs_d       <= vs;
      ce_d       <= vga_colorEn;
      frame_done <= 1'b0;

      if (hs_edge) begin
        hcnt    <= CNT_W'(1);
        hs_seen <= 1'b1;
        if (hs_seen) h_period <= hcnt;
      end else if (hcnt != CNT_MAX) begin
        hcnt <= hcnt + 1'b1;
      end

      if (frame_start) begin
        state   <= FRAME;
        pcnt    <= vga_colorEn ? CNT_W'(1) : '0;
        lcnt    <= '0;
        pix_acc <= 1'b0;
        if (in_frame) begin
          frame_done  <= 1'b1;
          frame_crc   <= crc;
          frame_lines <= lines_close;
          pix_err     <= pix_close;
          line_err    <= (lines_close != V_REQ);
          crc_ok      <= (crc == exp_crc);
          frame_count <= frame_count + 16'd1;
        end
      end else if (in_frame) begin
        if (line_close) begin
          pcnt    <= '0;
          lcnt    <= lines_close;
          pix_acc <= pix_close;
        end else if (vga_colorEn && (pcnt != CNT_MAX)) begin
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end

endmodule
